// File: rtl/rmii_pkg.sv
// Shared types and constants for the RMII receive front end.
package rmii_pkg;
  typedef logic [1:0] dibit_t;
  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DROP} rx_state_t;
  localparam dibit_t DIBIT_PRE = 2'b01;
  localparam dibit_t DIBIT_SFD = 2'b11;
endpackage

// File: rtl/rmii_byte_reorder.sv
// Ping-pong 4-dibit byte buffer: fills LSB-first, drains MSB-first, and
// reports end of frame once the last complete byte has left.
module rmii_byte_reorder
  import rmii_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_wr_en,
  input  dibit_t i_wr_dib,
  input  logic   i_end,
  output logic   o_partial,
  output logic   o_axiov,
  output dibit_t o_axiod,
  output logic   o_frame_done
);
  logic [1:0][3:0][1:0] r_buf;
  logic [1:0]           r_full;
  logic                 r_wr_sel, r_rd_sel;
  logic [1:0]           r_dib_cnt, r_out_idx;
  logic                 r_pend;
  logic [1:0]           w_full_set, w_full_clr;
  logic                 w_rd_ok;

  assign w_rd_ok    = r_full[r_rd_sel];
  assign w_full_set = (i_wr_en && r_dib_cnt == 2'd3) ? (2'b01 << r_wr_sel) : 2'b00;
  assign w_full_clr = (w_rd_ok && r_out_idx == 2'd3) ? (2'b01 << r_rd_sel) : 2'b00;
  assign o_partial  = (r_dib_cnt != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf        <= '0;
      r_full       <= 2'b00;
      r_wr_sel     <= 1'b0;
      r_rd_sel     <= 1'b0;
      r_dib_cnt    <= 2'd0;
      r_out_idx    <= 2'd0;
      r_pend       <= 1'b0;
      o_axiov      <= 1'b0;
      o_axiod      <= '0;
      o_frame_done <= 1'b0;
    end else begin
      r_full <= (r_full | w_full_set) & ~w_full_clr;
      // a carrier drop discards any partial byte; the write slot stays put
      if (i_end) begin
        r_dib_cnt <= 2'd0;
      end else if (i_wr_en) begin
        r_buf[r_wr_sel][r_dib_cnt] <= i_wr_dib;
        r_dib_cnt                  <= r_dib_cnt + 2'd1;
        if (r_dib_cnt == 2'd3) r_wr_sel <= ~r_wr_sel;
      end
      if (w_rd_ok) begin
        o_axiov      <= 1'b1;
        o_axiod      <= r_buf[r_rd_sel][2'd3 - r_out_idx];
        r_out_idx    <= r_out_idx + 2'd1;
        o_frame_done <= 1'b0;
        if (r_out_idx == 2'd3) r_rd_sel <= ~r_rd_sel;
      end else begin
        o_axiov      <= 1'b0;
        o_axiod      <= '0;
        o_frame_done <= r_pend;
        r_pend       <= 1'b0;
      end
      if (i_end) r_pend <= 1'b1;
    end
  end
endmodule

// File: rtl/rmii_rx_frontend.sv
// RMII receive front end: preamble/SFD qualification FSM and error pulses;
// payload reordering lives in rmii_byte_reorder.
module rmii_rx_frontend
  import rmii_pkg::*;
#(
  parameter int MIN_PREAMBLE = 6,
  parameter int MAX_PREAMBLE = 31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       crsdv,
  input  logic [1:0] rxd,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       frame_done,
  output logic       preamble_err,
  output logic       align_err
);
  localparam logic [4:0] MIN5 = 5'(MIN_PREAMBLE);
  localparam logic [5:0] MAX6 = 6'(MAX_PREAMBLE);

  rx_state_t  r_state;
  logic [4:0] r_pre_cnt;
  logic       r_perr, r_aerr;
  logic [4:0] w_pre_inc;
  logic       w_wr_en, w_end, w_partial;

  assign w_pre_inc = (r_pre_cnt == 5'd31) ? 5'd31 : r_pre_cnt + 5'd1;
  assign w_wr_en   = (r_state == PAYLOAD) && crsdv;
  assign w_end     = (r_state == PAYLOAD) && !crsdv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pre_cnt <= 5'd0;
      r_perr    <= 1'b0;
      r_aerr    <= 1'b0;
    end else begin
      r_perr <= 1'b0;
      r_aerr <= 1'b0;
      case (r_state)
        IDLE: begin
          // crsdv with rxd=00 is false carrier and is ignored
          if (crsdv && rxd != 2'b00) begin
            if (rxd == DIBIT_PRE) begin
              r_state   <= PREAMBLE;
              r_pre_cnt <= 5'd1;
            end else begin
              r_perr  <= 1'b1;
              r_state <= DROP;
            end
          end
        end
        PREAMBLE: begin
          if (!crsdv) begin
            r_perr  <= 1'b1;
            r_state <= IDLE;
          end else if (rxd == DIBIT_PRE) begin
            r_pre_cnt <= w_pre_inc;
            if ({1'b0, w_pre_inc} > MAX6) begin
              r_perr  <= 1'b1;
              r_state <= DROP;
            end
          end else if (rxd == DIBIT_SFD && r_pre_cnt >= MIN5) begin
            r_state <= PAYLOAD;
          end else begin
            r_perr  <= 1'b1;
            r_state <= DROP;
          end
        end
        PAYLOAD: begin
          if (!crsdv) begin
            r_state <= IDLE;
            r_aerr  <= w_partial;
          end
        end
        DROP: if (!crsdv) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  rmii_byte_reorder u_reorder (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr_en     (w_wr_en),
    .i_wr_dib    (rxd),
    .i_end       (w_end),
    .o_partial   (w_partial),
    .o_axiov     (axiov),
    .o_axiod     (axiod),
    .o_frame_done(frame_done)
  );

  assign preamble_err = r_perr;
  assign align_err    = r_aerr;
endmodule
